fetch_queue_unit: RTL and testbench
===================================

# fetch_queue_unit

Decoupled instruction fetch unit with a parametrised prefetch queue. It issues sequential word reads to the instruction memory interface ahead of decode, buffers up to QUEUE_DEPTH returned {PC, instruction} pairs, and presents them to decode with a valid/stall handshake. Taken JAL/JALR/branch redirects flush the queue and squash stale in-flight responses. It sits between the core's decode stage and the instruction-side mem_interface.

## Interface
- CORE, 0: core index, used in report output only
- DATA_WIDTH, 32: instruction width
- ADDRESS_BITS, 20: byte-address width of PC and targets
- QUEUE_DEPTH, 4: prefetch entries; power of two, ≥2
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- start  in  1  load program_address into fetch PC, flush queue
- program_address  in  ADDRESS_BITS  boot byte address
- PC_select  in  2  00 next, 01 branch, 10 JAL, 11 JALR
- branch  in  1  branch taken, qualifies PC_select==01
- JAL_target, JALR_target, branch_target  in  ADDRESS_BITS each  redirect byte addresses
- stall  in  1  decode not accepting this cycle
- instruction  out  DATA_WIDTH  queue head instruction
- inst_PC  out  ADDRESS_BITS  queue head byte PC
- valid  out  1  head entry present
- mem_read  out  1  one-cycle read request
- mem_address  out  ADDRESS_BITS  word address (fetch PC >> 2)
- mem_ready  in  1  memory interface accepts a request this cycle
- mem_valid  in  1  response present
- mem_out_addr  in  ADDRESS_BITS  word address of response
- mem_out_data  in  DATA_WIDTH  response instruction
- report  in  1  print state via $display

## Operation
- Redirect = start, or PC_select==10, or 11, or (01 & branch). Target priority: start→program_address, 10→JAL, 11→JALR, 01→branch_target.
- Redirect: flush queue, set fetch PC and expected-response PC to target, clear nothing else; in-flight count is retained, stale responses dropped by address match.
- Issue: mem_read=1 with mem_address=fetch_PC>>2 when not reset, not redirecting, mem_ready=1, and occupancy + inflight < QUEUE_DEPTH. On issue fetch_PC += 4 (mod 2^ADDRESS_BITS), inflight++.
- Response (mem_valid=1): inflight--. Pushed only if mem_out_addr == expected_PC>>2 and no redirect this cycle; then expected_PC += 4. Otherwise discarded.
- Pop: valid & !stall & no redirect. Redirect same cycle wins; pop ignored.
- Push and pop same cycle legal at any occupancy; credit rule makes overflow impossible. inflight never underflows; response with inflight==0 is ignored.
- report: one $display block of fetch_PC, expected_PC, occupancy, inflight, head, handshake signals.

## Timing
- Reset values: valid 0, instruction 0, inst_PC 0, mem_read 0, mem_address 0, occupancy 0, inflight 0, fetch_PC 0.
- start at cycle t → earliest mem_read at t+1, address program_address>>2.
- Response pushed at cycle r → valid=1, head visible at r+1 (no bypass).
- Pop at cycle p → next entry at head from p+1.
- Redirect at cycle t → valid=0 at t+1; first request to target at t+1 if credits allow.
- Steady state with single-cycle memory and no stall: one instruction per cycle once queue primed.
- reset mid-operation overrides everything including start; next cycle all state at reset values.

## Structure
- Shared package: PC_select encodings (PC_SEL_NEXT, PC_SEL_BRANCH, PC_SEL_JAL, PC_SEL_JALR), PC increment constant 4.
- Sub-module fetch_queue: synchronous FIFO of {ADDRESS_BITS PC, DATA_WIDTH inst}, QUEUE_DEPTH entries, push/pop/flush, count output, registered storage, head read combinational from storage.
- Top holds fetch_PC, expected_PC, inflight counter (clog2(QUEUE_DEPTH)+1 bits), redirect decode.

## Test plan
- Boot: reset, start with program_address=0x00100 → mem_address 0x00040,0x00041,…; valid at first response+1, inst_PC 0x00100,0x00104.
- Backpressure: stall=1 with 1-cycle memory, QUEUE_DEPTH=4 → exactly 4 requests issued, mem_read stays 0 until a pop.
- Redirect with in-flight: JAL_target=0x00200 while 2 requests outstanding → stale responses discarded, next valid head inst_PC=0x00200.
- Simultaneous pop+redirect: stall=0, PC_select=11 → popped entry not consumed twice, queue empty next cycle, valid=0.
- Wrap: start at 0xFFFFC, ADDRESS_BITS=20 → second inst_PC 0x00000.
- Reset mid-stream with queue full → all outputs 0 next cycle, no mem_read until start.

Source files
------------

// File: rtl/fetch_queue_unit_pkg.sv
// Shared definitions for the instruction fetch unit: PC source select
// encodings and the sequential fetch stride.
package fetch_queue_unit_pkg;

  typedef enum logic [1:0] {
    PC_SEL_NEXT   = 2'b00,
    PC_SEL_BRANCH = 2'b01,
    PC_SEL_JAL    = 2'b10,
    PC_SEL_JALR   = 2'b11
  } pc_sel_e;

  // Byte stride between consecutive instruction words.
  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {PC, instruction} pairs. Flush empties the queue and
// takes priority over push/pop. The head is read combinationally from the
// registered storage, so a pushed entry is visible one cycle later.
module fetch_queue #(
  parameter int ADDRESS_BITS = 20,
  parameter int DATA_WIDTH   = 32,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  logic [ADDRESS_BITS-1:0]        push_pc,
  input  logic [DATA_WIDTH-1:0]          push_inst,
  output logic [ADDRESS_BITS-1:0]        head_pc,
  output logic [DATA_WIDTH-1:0]          head_inst,
  output logic [$clog2(QUEUE_DEPTH):0]   count,
  output logic                           empty
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDRESS_BITS-1:0] pc_mem_q   [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]   inst_mem_q [QUEUE_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointer and occupancy update; flush clears everything.
  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop & ~flush & (count_q != '0);
    do_push  = push & ~flush & ((count_q != CNT_W'(QUEUE_DEPTH)) | do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write.
  // NOTE: the storage array is deliberately not reset; an entry is only
  // observed once the count says it was written, and outputs are gated.
  always_ff @(posedge clock) begin
    if (do_push) begin
      pc_mem_q[wr_ptr_q]   <= push_pc;
      inst_mem_q[wr_ptr_q] <= push_inst;
    end
  end

  assign head_pc   = pc_mem_q[rd_ptr_q];
  assign head_inst = inst_mem_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);

endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled instruction fetch: issues sequential word reads ahead of
// decode under a credit limit (queue occupancy + in-flight <= depth),
// buffers returned instructions, and flushes on redirects. Stale responses
// are dropped because their address no longer matches expected_pc.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] program_address,
  input  logic [1:0]              PC_select,
  input  logic                    branch,
  input  logic [ADDRESS_BITS-1:0] JAL_target,
  input  logic [ADDRESS_BITS-1:0] JALR_target,
  input  logic [ADDRESS_BITS-1:0] branch_target,
  input  logic                    stall,
  output logic [DATA_WIDTH-1:0]   instruction,
  output logic [ADDRESS_BITS-1:0] inst_PC,
  output logic                    valid,
  output logic                    mem_read,
  output logic [ADDRESS_BITS-1:0] mem_address,
  input  logic                    mem_ready,
  input  logic                    mem_valid,
  input  logic [ADDRESS_BITS-1:0] mem_out_addr,
  input  logic [DATA_WIDTH-1:0]   mem_out_data,
  input  logic                    report
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_BITS-1:0] expected_pc_q, expected_pc_d;
  logic [CNT_W-1:0]        inflight_q, inflight_d;
  logic                    started_q, started_d;

  logic                    redirect;
  logic [ADDRESS_BITS-1:0] redirect_target;
  logic                    issue, resp_taken, push, pop;
  logic [CNT_W-1:0]        occupancy;
  logic [CNT_W:0]          credits_used;
  logic                    q_empty;
  logic [ADDRESS_BITS-1:0] head_pc;
  logic [DATA_WIDTH-1:0]   head_inst;

  // The state dump hook and core index only matter to simulation-side
  // reporting and have no hardware counterpart.
  logic        report_unused;
  logic [31:0] core_id_unused;
  assign report_unused  = report;
  assign core_id_unused = 32'(CORE);

  // Redirect decode: start outranks every PC_select source.
  always_comb begin
    redirect        = 1'b0;
    redirect_target = '0;
    if (start) begin
      redirect        = 1'b1;
      redirect_target = program_address;
    end else begin
      case (pc_sel_e'(PC_select))
        PC_SEL_JAL: begin
          redirect        = 1'b1;
          redirect_target = JAL_target;
        end
        PC_SEL_JALR: begin
          redirect        = 1'b1;
          redirect_target = JALR_target;
        end
        PC_SEL_BRANCH: begin
          redirect        = branch;
          redirect_target = branch_target;
        end
        PC_SEL_NEXT: ;
      endcase
    end
  end

  // Issue credit, response acceptance and decode handshake.
  always_comb begin
    credits_used = {1'b0, occupancy} + {1'b0, inflight_q};
    issue        = ~reset & started_q & ~redirect & mem_ready &
                   (credits_used < (CNT_W+1)'(QUEUE_DEPTH));
    resp_taken   = mem_valid & (inflight_q != '0);
    push         = resp_taken & ~redirect & (mem_out_addr == (expected_pc_q >> 2));
    pop          = ~q_empty & ~stall & ~redirect;
  end

  // Next fetch PC, expected response PC and in-flight count.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    expected_pc_d = expected_pc_q;
    inflight_d    = inflight_q;
    started_d     = started_q | start;
    if (redirect) begin
      fetch_pc_d    = redirect_target;
      expected_pc_d = redirect_target;
    end else begin
      if (issue) fetch_pc_d    = fetch_pc_q + ADDRESS_BITS'(PC_INCR);
      if (push)  expected_pc_d = expected_pc_q + ADDRESS_BITS'(PC_INCR);
    end
    case ({issue, resp_taken})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: ;
    endcase
  end

  // Fetch state registers; reset overrides start.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= '0;
      expected_pc_q <= '0;
      inflight_q    <= '0;
      started_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      expected_pc_q <= expected_pc_d;
      inflight_q    <= inflight_d;
      started_q     <= started_d;
    end
  end

  fetch_queue #(
    .ADDRESS_BITS (ADDRESS_BITS),
    .DATA_WIDTH   (DATA_WIDTH),
    .QUEUE_DEPTH  (QUEUE_DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_pc   (expected_pc_q),
    .push_inst (mem_out_data),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (occupancy),
    .empty     (q_empty)
  );

  assign valid       = ~q_empty;
  assign instruction = valid ? head_inst : '0;
  assign inst_PC     = valid ? head_pc : '0;
  assign mem_read    = issue;
  assign mem_address = fetch_pc_q >> 2;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit. Each redirect issued by the
// stimulus defines the instruction stream decode must see from then on
// (target, target+4, ...), pushed into an expected queue; a negedge
// monitor pops and compares on every accepted head and checks requests.
module tb_fetch_queue_unit;

  localparam int AB = 20;
  localparam int DW = 32;
  localparam int QD = 4;

  logic          clock = 1'b0;
  logic          reset, start, branch, stall, report;
  logic [AB-1:0] program_address, JAL_target, JALR_target, branch_target;
  logic [1:0]    PC_select;
  logic [DW-1:0] instruction;
  logic [AB-1:0] inst_PC, mem_address, mem_out_addr;
  logic          valid, mem_read, mem_ready, mem_valid;
  logic [DW-1:0] mem_out_data;

  always #5 clock = ~clock;

  fetch_queue_unit #(
    .CORE (0), .DATA_WIDTH (DW), .ADDRESS_BITS (AB), .QUEUE_DEPTH (QD)
  ) dut (
    .clock (clock), .reset (reset), .start (start),
    .program_address (program_address), .PC_select (PC_select),
    .branch (branch), .JAL_target (JAL_target), .JALR_target (JALR_target),
    .branch_target (branch_target), .stall (stall),
    .instruction (instruction), .inst_PC (inst_PC), .valid (valid),
    .mem_read (mem_read), .mem_address (mem_address), .mem_ready (mem_ready),
    .mem_valid (mem_valid), .mem_out_addr (mem_out_addr),
    .mem_out_data (mem_out_data), .report (report)
  );

  typedef struct { logic [AB-1:0] pc; logic [DW-1:0] inst; } entry_t;
  typedef struct { logic [AB-1:0] waddr; int unsigned due; } req_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  entry_t      exp_q[$];
  logic [AB-1:0] exp_next_pc = '0;
  req_t        pend_q[$];
  int unsigned last_due = 0;
  int unsigned lat_lo = 1, lat_hi = 1;
  logic [AB-1:0] req_pc = '0;
  logic        started_model = 1'b0;
  logic        redir_prev = 1'b0;
  int unsigned req_cnt = 0, acc_cnt = 0;
  logic [AB-1:0] acc_pc_q[$];

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [DW-1:0] inst_of(logic [AB-1:0] w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [AB-1:0] rand_pc();
    return AB'($urandom) & ~(AB'(3));
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic refill();
    entry_t e;
    while (exp_q.size() < 64) begin
      e.pc   = exp_next_pc;
      e.inst = inst_of(exp_next_pc >> 2);
      exp_q.push_back(e);
      exp_next_pc = exp_next_pc + AB'(4);
    end
  endtask

  task automatic model_redirect(logic [AB-1:0] tgt);
    exp_q.delete();
    exp_next_pc = tgt;
    refill();
    req_pc = tgt;
  endtask

  task automatic do_start(logic [AB-1:0] a);
    start = 1'b1;
    program_address = a;
    started_model = 1'b1;
    model_redirect(a);
  endtask

  task automatic do_jump(logic [1:0] sel, logic [AB-1:0] a);
    PC_select = sel;
    case (sel)
      2'b01: begin branch = 1'b1; branch_target = a; end
      2'b10: JAL_target = a;
      2'b11: JALR_target = a;
      default: ;
    endcase
    model_redirect(a);
  endtask

  // Advance one cycle; drive the memory response and clear one-shot inputs.
  task automatic step();
    req_t r;
    @(posedge clock);
    #1;
    cyc++;
    start = 1'b0;
    PC_select = 2'b00;
    branch = 1'b0;
    if (exp_q.size() < 32) refill();
    mem_valid = 1'b0;
    mem_out_addr = '0;
    mem_out_data = '0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      r = pend_q.pop_front();
      mem_valid = 1'b1;
      mem_out_addr = r.waddr;
      mem_out_data = inst_of(r.waddr);
    end
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    pend_q.delete();
    exp_q.delete();
    started_model = 1'b0;
    repeat (n) step();
    reset = 1'b0;
    last_due = cyc;
  endtask

  task automatic wait_head(string name, logic [AB-1:0] pc);
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (valid) break;
      step();
    end
    check({name, "_valid"}, 64'(valid), 64'(1));
    check({name, "_pc"}, 64'(inst_PC), 64'(pc));
  endtask

  // Monitor: request capture into the memory model, request address check,
  // scoreboard compare on every accepted head, post-redirect empty check.
  always @(negedge clock) begin
    logic        redir_now, acc;
    entry_t      e;
    req_t        r;
    int unsigned lat;
    redir_now = start | (PC_select == 2'b10) | (PC_select == 2'b11) |
                ((PC_select == 2'b01) & branch);
    if (reset) begin
      check("mem_read_in_reset", 64'(mem_read), 64'(0));
      redir_prev = 1'b0;
    end else begin
      if (redir_prev) check("valid_after_redirect", 64'(valid), 64'(0));
      if (redir_now) check("no_issue_on_redirect", 64'(mem_read), 64'(0));
      if (mem_read) begin
        if (!started_model) begin
          check("mem_read_before_start", 64'(mem_read), 64'(0));
        end else begin
          check("mem_read_needs_ready", 64'(mem_ready), 64'(1));
          check("req_addr", 64'(mem_address), 64'(req_pc >> 2));
        end
        req_pc = req_pc + AB'(4);
        req_cnt++;
        lat = $urandom_range(lat_lo, lat_hi);
        r.waddr = mem_address;
        r.due = cyc + lat;
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        pend_q.push_back(r);
      end
      acc = valid & ~stall & ~redir_now;
      if (acc) begin
        acc_cnt++;
        acc_pc_q.push_back(inst_PC);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected_accept: got pc %h expected no entry", inst_PC);
        end else begin
          e = exp_q.pop_front();
          check("head_pc", 64'(inst_PC), 64'(e.pc));
          check("head_inst", 64'(instruction), 64'(e.inst));
        end
      end
      redir_prev = redir_now;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base, rbase, a0, r;
    reset = 1'b1; start = 1'b0; branch = 1'b0; stall = 1'b0; report = 1'b0;
    program_address = '0; JAL_target = '0; JALR_target = '0; branch_target = '0;
    PC_select = 2'b00; mem_ready = 1'b1; mem_valid = 1'b0;
    mem_out_addr = '0; mem_out_data = '0;

    // Reset values, and no requests before start.
    do_reset(3);
    @(negedge clock);
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_instruction", 64'(instruction), 64'(0));
    check("rst_inst_pc", 64'(inst_PC), 64'(0));
    check("rst_mem_read", 64'(mem_read), 64'(0));
    check("rst_mem_address", 64'(mem_address), 64'(0));
    repeat (3) step();

    // Boot with single-cycle memory, no stall.
    step();
    base = acc_cnt;
    do_start(20'h00100);
    step(); @(negedge clock);
    check("boot_first_read", 64'(mem_read), 64'(1));
    check("boot_first_addr", 64'(mem_address), 64'(20'h00040));
    step(); @(negedge clock);
    check("boot_valid_not_yet", 64'(valid), 64'(0));
    step(); @(negedge clock);
    check("boot_valid", 64'(valid), 64'(1));
    check("boot_head_pc", 64'(inst_PC), 64'(20'h00100));
    repeat (20) step();
    check("boot_throughput", 64'(acc_cnt - base), 64'(20));

    // Backpressure: exactly QD requests, then one more only after a pop.
    do_reset(1);
    stall = 1'b1;
    step();
    rbase = req_cnt;
    do_start(20'h00100);
    repeat (12) step();
    @(negedge clock);
    check("bp_req_count", 64'(req_cnt - rbase), 64'(QD));
    check("bp_mem_read_held", 64'(mem_read), 64'(0));
    check("bp_full_valid", 64'(valid), 64'(1));
    step();
    stall = 1'b0;
    step();
    stall = 1'b1;
    @(negedge clock);
    check("bp_resume_read", 64'(mem_read), 64'(1));
    check("bp_resume_addr", 64'(mem_address), 64'(20'h00044));

    // Pop and JALR redirect in the same cycle.
    repeat (4) step();
    stall = 1'b0;
    do_jump(2'b11, 20'h00300);
    @(negedge clock);
    check("pr_valid_before", 64'(valid), 64'(1));
    step();
    stall = 1'b1;
    @(negedge clock);
    check("pr_queue_empty", 64'(valid), 64'(0));
    step();
    stall = 1'b0;
    wait_head("jalr_head", 20'h00300);

    // JAL redirect with two requests outstanding on slow memory.
    do_reset(1);
    lat_lo = 3; lat_hi = 3;
    step();
    do_start(20'h00100);
    step();
    step();
    step();
    do_jump(2'b10, 20'h00200);
    step();
    wait_head("jal_head", 20'h00200);
    repeat (10) step();
    lat_lo = 1; lat_hi = 1;

    // PC wrap at the top of the address space.
    do_reset(1);
    step();
    a0 = acc_pc_q.size();
    do_start(20'hFFFFC);
    repeat (8) step();
    check("wrap_count", 64'(acc_pc_q.size() >= a0 + 2), 64'(1));
    check("wrap_first", 64'(acc_pc_q[a0]), 64'(20'hFFFFC));
    check("wrap_second", 64'(acc_pc_q[a0 + 1]), 64'(20'h00000));

    // Reset mid-stream with a full queue, start asserted alongside reset.
    do_reset(1);
    stall = 1'b1;
    step();
    do_start(20'h00100);
    repeat (10) step();
    @(negedge clock);
    check("mid_full_valid", 64'(valid), 64'(1));
    step();
    reset = 1'b1;
    start = 1'b1;
    program_address = 20'h00500;
    pend_q.delete();
    exp_q.delete();
    started_model = 1'b0;
    step();
    reset = 1'b0;
    last_due = cyc;
    @(negedge clock);
    check("mid_rst_valid", 64'(valid), 64'(0));
    check("mid_rst_instruction", 64'(instruction), 64'(0));
    check("mid_rst_inst_pc", 64'(inst_PC), 64'(0));
    check("mid_rst_mem_read", 64'(mem_read), 64'(0));
    check("mid_rst_mem_address", 64'(mem_address), 64'(0));
    repeat (4) step();

    // Randomized traffic: stalls, memory backpressure, variable latency,
    // redirects of every kind with the unused targets randomized.
    lat_lo = 1; lat_hi = 3;
    stall = 1'b0;
    step();
    do_start(rand_pc());
    base = acc_cnt;
    repeat (3000) begin
      step();
      stall = ($urandom_range(0, 9) < 3);
      mem_ready = ($urandom_range(0, 9) < 8);
      JAL_target = rand_pc();
      JALR_target = rand_pc();
      branch_target = rand_pc();
      program_address = rand_pc();
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_start(rand_pc());
        PC_select = 2'($urandom_range(0, 3));
        branch = 1'($urandom_range(0, 1));
      end else if (r < 4) begin
        do_jump(2'b10, rand_pc());
      end else if (r < 6) begin
        do_jump(2'b11, rand_pc());
      end else if (r < 9) begin
        do_jump(2'b01, rand_pc());
      end else if (r < 13) begin
        PC_select = 2'b01;
        branch = 1'b0;
      end
    end
    check("rand_progress", 64'((acc_cnt - base) > 100), 64'(1));
    stall = 1'b0;
    mem_ready = 1'b1;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
